kd_tree_loader: RTL and testbench
=================================

Name: kd_tree_loader

Overview:
- Synthesizable upstream controller for the kd-tree node array; sits between the centre/pixel memory and the root node's top port.
- Runs the bring-up sequence: tree reset, centre streaming (center_fill), sort launch (start_sorting), wait for valid_sort.
- Reports done or error to the top-level k-means sequencer.

Parameters:
- COMMAND_SIZE, 5, width of node command bus.
- DATA_SIZE, 24, width of node data bus (packed RGB).
- DATA_NUM, 20, number of entries available in source memory; fill aborts if exhausted.
- ADDR_W, 5, source memory address width; must satisfy 2^ADDR_W >= DATA_NUM.
- TIMEOUT, 1023, max cycles waiting for any root acknowledge.
- TO_W, 10, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle request to run a full load+sort; ignored unless idle.
- mem_addr, out, ADDR_W, source memory read address.
- mem_rdata, in, DATA_SIZE, memory data; valid exactly 1 cycle after mem_addr is presented.
- command_to_root, out, COMMAND_SIZE, drives root command_from_top.
- data_to_root, out, DATA_SIZE, drives root data_from_top.
- command_from_root, in, COMMAND_SIZE, root command_to_top.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse on successful sort.
- error, out, 1, sticky; cleared by reset or the next accepted start.
- err_code, out, 2, 01 = rst timeout, 10 = memory exhausted before center_fill_done, 11 = sort timeout.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- All outputs registered. Reset values: command_to_root = nop (5'h00), data_to_root = 0, mem_addr = 0, busy = 0, done = 0, error = 0, err_code = 0; state = IDLE; timeout counter = 0.
- States:
  - IDLE: drive nop. On start, clear error/err_code and go to TREE_RST.
  - TREE_RST: drive rst (5'h1f) each cycle.
    - command_from_root == rst_done (5'h1e): go to PREFETCH.
    - Timeout counter reaches TIMEOUT: go to ERR with code 01.
  - PREFETCH: drive nop. mem_addr = 0. Next cycle go to FILL with mem_addr = 1.
  - FILL: each cycle drive command_to_root = center_fill (5'h01) and data_to_root = mem_rdata, then increment mem_addr.
    - command_from_root == center_fill_done (5'h05): go to SORT_START; nothing further issued.
    - center_fill_done is checked before issuing, so a same-cycle done wins.
    - DATA_NUM words issued without center_fill_done: go to ERR with code 10.
  - SORT_START: one cycle of start_sorting (5'h09), data 0. Go to SORT_WAIT.
  - SORT_WAIT: drive nop.
    - command_from_root == valid_sort (5'h0f): pulse done for 1 cycle, go to IDLE.
    - Timeout: go to ERR with code 11.
  - ERR: drive nop, assert error, go to IDLE the following cycle. error stays high.
- Timeout counter clears on every state change and saturates at TIMEOUT.
- start while busy is ignored, with no queuing.
- reset mid-operation forces IDLE and nop on the next edge. The tree is not reset until the next start issues rst.
- Latency, start to first rst on bus: 1 cycle.
- Latency, rst_done to first center_fill: 2 cycles (PREFETCH + FILL register).
- mem_addr must not wrap: it stops at DATA_NUM.

Decomposition:
- Shared package kd_tree_pkg holds:
  - COMMAND_SIZE and DATA_SIZE.
  - All node command localparams: nop, rst, rst_done, center_fill, center_fill_done, start_sorting, valid_sort, dne, etc.
  - The err_code constants.
- The node array and this block both import kd_tree_pkg.
- One natural sub-module: kd_ack_timer (load/clear, saturating count, expired flag), reused per wait state.

Test Plan:
- Ack after delay: reset, start; root model returns rst_done after 3 cycles -> command_to_root = 5'h1f for 3 cycles then nop; busy = 1 throughout.
- Fill and sort: memory holds 0x000001..0x000014; model asserts center_fill_done after 7 words -> data_to_root sequence 0x000001..0x000007, each with cmd 5'h01. Then exactly one 5'h09, then nop. valid_sort after 10 cycles -> done pulses exactly one cycle, busy drops the same edge.
- No fill ack: root never asserts center_fill_done -> 20 fills issued, mem_addr stops at 20, error = 1, err_code = 10, no start_sorting ever seen.
- Sort timeout: TIMEOUT = 15, valid_sort never returns -> err_code = 11 sixteen cycles after SORT_START; next start clears error.
- Reset mid-fill: reset asserted during the 4th fill word -> next edge command_to_root = nop, all outputs at reset values; start pulsed while busy in a separate run has no effect.

Source files
------------

// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: definitions shared by the kd-tree node array and its loader.
// Holds the node bus widths, the node command encodings, the loader error
// codes and the loader state type.
package kd_tree_pkg;

    localparam int COMMAND_SIZE = 5;
    localparam int DATA_SIZE    = 24;

    // Node command encodings on the command buses
    localparam logic [COMMAND_SIZE-1:0] CMD_NOP              = 5'h00;
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL      = 5'h01;
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL_DONE = 5'h05;
    localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING    = 5'h09;
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_SORT       = 5'h0f;
    localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE         = 5'h1e;
    localparam logic [COMMAND_SIZE-1:0] CMD_RST              = 5'h1f;

    // Loader error codes reported on err_code
    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_RST_TIMEOUT   = 2'b01;
    localparam logic [1:0] ERR_MEM_EXHAUSTED = 2'b10;
    localparam logic [1:0] ERR_SORT_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TREE_RST   = 3'd1,
        ST_PREFETCH   = 3'd2,
        ST_FILL       = 3'd3,
        ST_SORT_START = 3'd4,
        ST_SORT_WAIT  = 3'd5,
        ST_ERR        = 3'd6
    } loader_state_t;

endpackage

// File: rtl/kd_tree_loader_if.sv
// kd_tree_loader_if: source-memory read port plus the root node's top port.
//   mem_addr          : read address presented to the centre/pixel memory
//   mem_rdata         : memory data, valid one cycle after mem_addr
//   command_to_root   : command into the root node (command_from_top)
//   data_to_root      : data into the root node (data_from_top)
//   command_from_root : root node response (command_to_top)
// master = loader side, slave = memory/root side.
interface kd_tree_loader_if
    import kd_tree_pkg::*;
#(
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_SIZE-1:0]    mem_rdata;
    logic [COMMAND_SIZE-1:0] command_to_root;
    logic [DATA_SIZE-1:0]    data_to_root;
    logic [COMMAND_SIZE-1:0] command_from_root;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output command_to_root,
        output data_to_root,
        input  command_from_root
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  command_to_root,
        input  data_to_root,
        output command_from_root
    );

endinterface

// File: rtl/kd_ack_timer.sv
// kd_ack_timer: saturating cycle counter used to bound waits for a root
// acknowledge.
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart the count from zero on the next edge
//   expired    : count has reached TIMEOUT (holds there until cleared)
module kd_ack_timer #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic expired
);

    logic [TO_W-1:0] count_r;

    // Count cycles since the last clear, holding at TIMEOUT
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (count_r != TO_W'(TIMEOUT)) begin
            count_r <= count_r + TO_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == TO_W'(TIMEOUT));

endmodule

// File: rtl/kd_tree_loader.sv
// kd_tree_loader: bring-up controller for the kd-tree node array. On start it
// resets the tree, streams DATA_NUM-bounded centres from memory into the root
// with center_fill, launches sorting and waits for valid_sort.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle run request, honoured only while idle
//   bus        : memory read port and root node top port (master side)
//   busy       : high whenever not idle
//   done       : one-cycle pulse on a successful sort
//   error      : sticky failure flag, cleared by reset or an accepted start
//   err_code   : cause of the last failure
module kd_tree_loader
    import kd_tree_pkg::*;
#(
    parameter int DATA_NUM = 20,
    parameter int ADDR_W   = 5,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    kd_tree_loader_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code
);

    // One extra bit so the address and word count can hold DATA_NUM itself
    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] LAST_WORD = AW1'(DATA_NUM);

    loader_state_t  state_r;
    logic [AW1-1:0] addr_r;
    logic [AW1-1:0] fill_cnt_r;
    logic           timer_clr_s;
    logic           timer_expired_s;
    logic           rsp_rst_done_s;
    logic           rsp_fill_done_s;
    logic           rsp_valid_sort_s;

    assign rsp_rst_done_s   = (bus.command_from_root == CMD_RST_DONE);
    assign rsp_fill_done_s  = (bus.command_from_root == CMD_CENTER_FILL_DONE);
    assign rsp_valid_sort_s = (bus.command_from_root == CMD_VALID_SORT);
    assign bus.mem_addr     = addr_r[ADDR_W-1:0];

    // Timer runs only inside a wait state and restarts on every state change
    always_comb begin
        timer_clr_s = 1'b1;
        case (state_r)
            ST_TREE_RST: begin
                if (rsp_rst_done_s || timer_expired_s) begin
                    timer_clr_s = 1'b1;
                end else begin
                    timer_clr_s = 1'b0;
                end
            end
            ST_SORT_WAIT: begin
                if (rsp_valid_sort_s || timer_expired_s) begin
                    timer_clr_s = 1'b1;
                end else begin
                    timer_clr_s = 1'b0;
                end
            end
            default: timer_clr_s = 1'b1;
        endcase
    end

    kd_ack_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr_s),
        .expired (timer_expired_s)
    );

    // Loader sequencer: state plus every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r             <= ST_IDLE;
            bus.command_to_root <= CMD_NOP;
            bus.data_to_root    <= '0;
            addr_r              <= '0;
            fill_cnt_r          <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            err_code            <= ERR_NONE;
        end else begin
            done                <= 1'b0;
            bus.command_to_root <= CMD_NOP;
            bus.data_to_root    <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r             <= ST_TREE_RST;
                        bus.command_to_root <= CMD_RST;
                        busy                <= 1'b1;
                        error               <= 1'b0;
                        err_code            <= ERR_NONE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_TREE_RST: begin
                    if (rsp_rst_done_s) begin
                        state_r    <= ST_PREFETCH;
                        addr_r     <= '0;
                        fill_cnt_r <= '0;
                    end else if (timer_expired_s) begin
                        state_r  <= ST_ERR;
                        error    <= 1'b1;
                        err_code <= ERR_RST_TIMEOUT;
                    end else begin
                        bus.command_to_root <= CMD_RST;
                    end
                end
                ST_PREFETCH: begin
                    // Word 0 is read this cycle; word 1 is requested on entry to FILL
                    state_r <= ST_FILL;
                    addr_r  <= AW1'(1);
                end
                ST_FILL: begin
                    // A same-cycle center_fill_done beats issuing another word
                    if (rsp_fill_done_s) begin
                        state_r             <= ST_SORT_START;
                        bus.command_to_root <= CMD_START_SORTING;
                    end else if (fill_cnt_r == LAST_WORD) begin
                        state_r  <= ST_ERR;
                        error    <= 1'b1;
                        err_code <= ERR_MEM_EXHAUSTED;
                    end else begin
                        bus.command_to_root <= CMD_CENTER_FILL;
                        bus.data_to_root    <= bus.mem_rdata;
                        fill_cnt_r          <= fill_cnt_r + AW1'(1);
                        if (addr_r != LAST_WORD) begin
                            addr_r <= addr_r + AW1'(1);
                        end else begin
                            addr_r <= addr_r;
                        end
                    end
                end
                ST_SORT_START: begin
                    state_r <= ST_SORT_WAIT;
                end
                ST_SORT_WAIT: begin
                    if (rsp_valid_sort_s) begin
                        state_r <= ST_IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else if (timer_expired_s) begin
                        state_r  <= ST_ERR;
                        error    <= 1'b1;
                        err_code <= ERR_SORT_TIMEOUT;
                    end else begin
                        state_r <= ST_SORT_WAIT;
                    end
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kd_tree_loader.sv
// tb_kd_tree_loader: randomized self-checking bench for kd_tree_loader. A
// root-node responder and a one-cycle-latency memory surround the DUT; each
// run's per-cycle bus/status transcript is compared with a transcript built
// directly from the loader's bring-up rules.
module tb_kd_tree_loader;
    import kd_tree_pkg::*;

    localparam int DATA_NUM = 20;
    localparam int ADDR_W   = 5;
    localparam int TIMEOUT  = 15;
    localparam int TO_W     = 4;
    localparam int BUDGET   = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [DATA_SIZE-1:0] mem [32];

    kd_tree_loader_if #(.ADDR_W(ADDR_W)) bus ();

    kd_tree_loader #(
        .DATA_NUM (DATA_NUM),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (TO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Synchronous source memory: data one cycle after the address
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    function automatic logic [33:0] pack(input logic [4:0] c, input logic [23:0] d,
                                         input logic b, input logic dn, input logic e,
                                         input logic [1:0] code);
        return {c, d, b, dn, e, code};
    endfunction

    task automatic load_mem(input bit ramp);
        for (int i = 0; i < 32; i++) begin
            mem[i] = ramp ? 24'(i + 1) : 24'($urandom);
        end
    endtask

    // rst_d/fill_n/sort_d: cycle in which the root answers (0 = never answers)
    task automatic run_scenario(input string name, input int rst_d, input int fill_n,
                                input int sort_d, input bit poke);
        logic [33:0] exp_q[$];
        logic [33:0] obs_q[$];
        logic [4:0]  cmdv;
        int  n, cyc, rst_seen, fill_seen, wait_n, max_addr;
        bit  sort_seen, ended;

        n = (rst_d != 0) ? rst_d : TIMEOUT + 1;
        repeat (n) exp_q.push_back(pack(CMD_RST, 24'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        if (rst_d == 0) begin
            exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b1, 1'b0, 1'b1, 2'b01));
            exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b0, 1'b0, 1'b1, 2'b01));
        end else begin
            repeat (2) exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b1, 1'b0, 1'b0, 2'b00));
            n = (fill_n != 0) ? fill_n : DATA_NUM;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(pack(CMD_CENTER_FILL, mem[i], 1'b1, 1'b0, 1'b0, 2'b00));
            end
            if (fill_n == 0) begin
                exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b1, 1'b0, 1'b1, 2'b10));
                exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b0, 1'b0, 1'b1, 2'b10));
            end else begin
                exp_q.push_back(pack(CMD_START_SORTING, 24'd0, 1'b1, 1'b0, 1'b0, 2'b00));
                n = (sort_d != 0) ? sort_d : TIMEOUT + 1;
                repeat (n) exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b1, 1'b0, 1'b0, 2'b00));
                if (sort_d != 0) begin
                    exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b0, 1'b1, 1'b0, 2'b00));
                end else begin
                    exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b1, 1'b0, 1'b1, 2'b11));
                    exp_q.push_back(pack(CMD_NOP, 24'd0, 1'b0, 1'b0, 1'b1, 2'b11));
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        bus.command_from_root = CMD_NOP;
        cyc = 0; rst_seen = 0; fill_seen = 0; wait_n = 0; max_addr = 0;
        sort_seen = 1'b0; ended = 1'b0;
        while (!ended && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            cmdv = bus.command_to_root;
            obs_q.push_back(pack(cmdv,
                (cmdv == CMD_CENTER_FILL || cmdv == CMD_START_SORTING) ? bus.data_to_root : 24'd0,
                busy, done, error, err_code));
            if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
            bus.command_from_root = CMD_NOP;
            if (cmdv == CMD_RST) begin
                rst_seen++;
                if (rst_d != 0 && rst_seen == rst_d) bus.command_from_root = CMD_RST_DONE;
            end else if (cmdv == CMD_CENTER_FILL) begin
                fill_seen++;
                if (fill_n != 0 && fill_seen == fill_n) bus.command_from_root = CMD_CENTER_FILL_DONE;
            end else if (cmdv == CMD_START_SORTING) begin
                sort_seen = 1'b1;
            end else if (sort_seen && cmdv == CMD_NOP) begin
                wait_n++;
                if (sort_d != 0 && wait_n == sort_d) bus.command_from_root = CMD_VALID_SORT;
            end
            start = poke && (cyc == 2 || wait_n == 1);
            ended = !busy;
        end
        start = 1'b0;
        bus.command_from_root = CMD_NOP;

        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL %s run_end: busy still %0b after %0d cycles, required 0", name, busy, cyc);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s length: got %0d cycles, required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: got cmd=%h data=%h busy/done/err=%b%b%b code=%b, required cmd=%h data=%h busy/done/err=%b%b%b code=%b",
                         name, i + 1, obs_q[i][33:29], obs_q[i][28:5], obs_q[i][4], obs_q[i][3],
                         obs_q[i][2], obs_q[i][1:0], exp_q[i][33:29], exp_q[i][28:5],
                         exp_q[i][4], exp_q[i][3], exp_q[i][2], exp_q[i][1:0]);
            end
        end
        checks++;
        if (max_addr > DATA_NUM) begin
            errors++;
            $display("FAIL %s mem_addr_max: got %0d, required <= %0d", name, max_addr, DATA_NUM);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pack(bus.command_to_root, bus.data_to_root, busy, done, error, err_code), bus.mem_addr} !== 39'd0) begin
            errors++;
            $display("FAIL reset_values: got cmd=%h data=%h addr=%0d busy=%b done=%b err=%b code=%b, required all 0",
                     bus.command_to_root, bus.data_to_root, bus.mem_addr, busy, done, error, err_code);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.command_to_root !== CMD_NOP || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got cmd=%h busy=%b, required cmd=00 busy=0", bus.command_to_root, busy);
            end
        end
    endtask

    task automatic test_ack_after_delay();
        load_mem(1'b1);
        run_scenario("ack_delay_fill_sort", 3, 7, 10, 1'b0);
    endtask

    task automatic test_no_fill_ack();
        load_mem(1'b1);
        run_scenario("no_fill_ack", 3, 0, 5, 1'b0);
        checks++;
        if (bus.mem_addr !== 5'd20) begin
            errors++;
            $display("FAIL no_fill_ack mem_addr: got %0d, required 20", bus.mem_addr);
        end
    endtask

    task automatic test_sort_timeout();
        load_mem(1'b0);
        run_scenario("sort_timeout", 2, 4, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || err_code !== 2'b11) begin
            errors++;
            $display("FAIL sort_timeout sticky: got error=%b code=%b, required 1 11", error, err_code);
        end
        run_scenario("after_error_restart", 1, 2, 1, 1'b0);
    endtask

    task automatic test_rst_timeout();
        run_scenario("rst_timeout", 0, 3, 3, 1'b0);
    endtask

    task automatic test_boundary();
        load_mem(1'b0);
        run_scenario("boundary_last_chance", TIMEOUT + 1, DATA_NUM, TIMEOUT + 1, 1'b0);
        run_scenario("back_to_back", 1, 1, 1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        load_mem(1'b0);
        run_scenario("start_while_busy", 4, 5, 6, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        int cyc, rst_seen, fill_seen;
        load_mem(1'b1);
        @(negedge clk);
        start = 1'b1;
        cyc = 0; rst_seen = 0; fill_seen = 0;
        while (fill_seen < 4 && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            bus.command_from_root = CMD_NOP;
            if (bus.command_to_root == CMD_RST) begin
                rst_seen++;
                if (rst_seen == 2) bus.command_from_root = CMD_RST_DONE;
            end else if (bus.command_to_root == CMD_CENTER_FILL) begin
                fill_seen++;
            end
        end
        checks++;
        if (fill_seen < 4) begin
            errors++;
            $display("FAIL reset_mid_fill reach: got %0d fills in %0d cycles, required 4", fill_seen, cyc);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({pack(bus.command_to_root, bus.data_to_root, busy, done, error, err_code), bus.mem_addr} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid_fill values: got cmd=%h data=%h addr=%0d busy=%b done=%b err=%b code=%b, required all 0",
                     bus.command_to_root, bus.data_to_root, bus.mem_addr, busy, done, error, err_code);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.command_to_root !== CMD_NOP || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_fill idle: got cmd=%h busy=%b, required cmd=00 busy=0", bus.command_to_root, busy);
            end
        end
    endtask

    task automatic test_random();
        int rd, fn, sd, mode;
        for (int k = 0; k < 8; k++) begin
            load_mem(1'b0);
            rd   = $urandom_range(1, TIMEOUT + 1);
            fn   = $urandom_range(1, DATA_NUM);
            sd   = $urandom_range(1, TIMEOUT + 1);
            mode = $urandom_range(0, 5);
            if (mode == 0) rd = 0;
            if (mode == 1) fn = 0;
            if (mode == 2) sd = 0;
            run_scenario("random", rd, fn, sd, mode[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.command_from_root = CMD_NOP;
        load_mem(1'b1);
        test_reset();
        test_ack_after_delay();
        test_no_fill_ack();
        test_sort_timeout();
        test_rst_timeout();
        test_boundary();
        test_start_while_busy();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
